mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single 4-to-1 bit-select datapath between four requesters. It owns the 2-bit mux select, grants one requester at a time, and rotates priority so no requester is starved. The selected data bit is presented on `out` while a grant is active. It sits directly in front of the shared output line, replacing a free-running select input.

---
 rtl/mux4_rr_arbiter_if.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, data and grant signals shared between the
// requesters (master side) and the round-robin arbiter (slave side).
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] in;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       out;

   modport master (
      output req,
      output in,
      input  gnt,
      input  sel,
      input  valid,
      input  out
   );

   modport slave (
      input  req,
      input  in,
      output gnt,
      output sel,
      output valid,
      output out
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-to-1 bit mux.
// One requester is granted at a time. Priority rotates past each new
// winner. Handover to the next requester happens in the same edge as
// the release, so there is no idle gap.
// Optional burst limit: define MUX_ARB_BURST_LIMIT_EN to force
// re-arbitration after MAX_BURST consecutive grant cycles.
module mux4_rr_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic             clk,
   input  logic             rst,
   mux4_rr_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [1:0] sel_reg, sel_next;
   logic [3:0] gnt_reg, gnt_next;
   logic       valid_reg, valid_next;

   logic [1:0] arb_start;
   logic [3:0] rot_req;
   logic       win_found;
   logic [1:0] win_off;
   logic [1:0] win_idx;
   logic       rearb;
   logic       grant_new;
   logic       burst_expire;

   // Reject parameter sets the counter cannot represent.
   if (MAX_BURST < 1 || MAX_BURST > 255 || CNT_W < $clog2(MAX_BURST + 1)) begin : g_bad_cfg
      $error("mux4_rr_arbiter: MAX_BURST must be 1..255 and CNT_W wide enough to hold it");
   end

   // A forced rotation scans from the holder's successor, so the holder
   // itself is looked at last. Otherwise scanning starts at the pointer.
   assign arb_start = burst_expire ? (sel_reg + 2'd1) : ptr_reg;

   // Rotate the request vector so that bit 0 is the highest-priority index.
   for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = bus.req[arb_start + 2'(gi)];
   end

   // Fixed-priority pick on the rotated vector, mapped back to an index.
   always_comb begin
      win_off = 2'd0;
      if (rot_req[0]) begin
         win_off = 2'd0;
      end else if (rot_req[1]) begin
         win_off = 2'd1;
      end else if (rot_req[2]) begin
         win_off = 2'd2;
      end else begin
         win_off = 2'd3;
      end
   end

   assign win_found = |rot_req;
   assign win_idx   = arb_start + win_off;

`ifdef MUX_ARB_BURST_LIMIT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // The holder has used its last allowed cycle and still wants more.
   assign burst_expire = (state_reg == BUSY) && bus.req[sel_reg] && (cnt_reg == CNT_LAST);

   // Count cycles of the current grant; restart on every new grant,
   // including a forced rotation that the holder re-wins.
   always_comb begin
      cnt_next = cnt_reg;
      if (grant_new) begin
         cnt_next = '0;
      end else if (state_reg == BUSY && bus.req[sel_reg]) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // Burst counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
`else
   assign burst_expire = 1'b0;
`endif

   // Next-state and grant decision: arbitrate when idle, on release, or
   // on burst expiry; otherwise keep the current grant.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      sel_next   = sel_reg;
      gnt_next   = gnt_reg;
      rearb      = 1'b0;
      grant_new  = 1'b0;

      case (state_reg)
         IDLE: begin
            gnt_next = '0;
            rearb    = 1'b1;
         end
         BUSY: begin
            if (!bus.req[sel_reg] || burst_expire) begin
               rearb = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase

      if (rearb) begin
         if (win_found) begin
            state_next = BUSY;
            gnt_next   = 4'b0001 << win_idx;
            sel_next   = win_idx;
            ptr_next   = win_idx + 2'd1;
            grant_new  = 1'b1;
         end else begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      end

      valid_next = |gnt_next;
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         ptr_reg   <= 2'd0;
         sel_reg   <= 2'd0;
         gnt_reg   <= 4'd0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         sel_reg   <= sel_next;
         gnt_reg   <= gnt_next;
         valid_reg <= valid_next;
      end
   end

   assign bus.gnt   = gnt_reg;
   assign bus.sel   = sel_reg;
   assign bus.valid = valid_reg;
   assign bus.out   = valid_reg ? bus.in[sel_reg] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: the driver applies one vector per
// cycle on the falling edge and queues the outputs expected after the
// next rising edge; the monitor checks them 1 time unit after that edge.
// Burst-limit expectations follow MUX_ARB_BURST_LIMIT_EN.
module tb_mux4_rr_arbiter;

   typedef struct {
      int         due;
      string      name;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       out;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   mux4_rr_arbiter_if bus();

   mux4_rr_arbiter #(.MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Apply one cycle of stimulus and queue the expected registered result.
   task automatic step(input string name, input logic r, input logic [3:0] rq,
                       input logic [3:0] din, input logic [3:0] eg,
                       input logic [1:0] es, input logic ev, input logic eo);
      exp_t e;
      @(negedge clk);
      rst     = r;
      bus.req = rq;
      bus.in  = din;
      e.due   = cyc + 1;
      e.name  = name;
      e.gnt   = eg;
      e.sel   = es;
      e.valid = ev;
      e.out   = eo;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation that falls due this cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.due != cyc ||
                bus.gnt !== e.gnt || bus.sel !== e.sel ||
                bus.valid !== e.valid || bus.out !== e.out) begin
               errors++;
               $display("FAIL %s cyc=%0d got gnt=%b sel=%0d valid=%b out=%b need gnt=%b sel=%0d valid=%b out=%b",
                        e.name, cyc, bus.gnt, bus.sel, bus.valid, bus.out,
                        e.gnt, e.sel, e.valid, e.out);
            end else begin
               $display("ok   %s cyc=%0d gnt=%b sel=%0d valid=%b out=%b",
                        e.name, cyc, bus.gnt, bus.sel, bus.valid, bus.out);
            end
         end
      end
   end

   initial begin
      logic [3:0] eg;
      logic [1:0] es;
      bus.req = 4'b0000;
      bus.in  = 4'b0000;

      // Reset, with requests that must be ignored.
      step("reset",        1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Single request from requester 2.
      step("single_gnt",   1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
      step("single_in0",   1'b0, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0);
      step("single_rel",   1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
      step("single_idle",  1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0);

      // All request; each drops after its grant, 0 comes back for the wrap.
      step("all_reset",    1'b1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("all_g0",       1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0);
      step("all_g1",       1'b0, 4'b1110, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
      step("all_g2",       1'b0, 4'b1101, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0);
      step("all_g3",       1'b0, 4'b1011, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
      step("all_wrap0",    1'b0, 4'b0111, 4'b1011, 4'b0001, 2'd0, 1'b1, 1'b1);
      step("all_idle",     1'b0, 4'b0000, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Pointer fairness: after a grant to 3, requester 0 beats 3.
      step("fair_g3",      1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
      step("fair_rel",     1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
      step("fair_g0",      1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
      step("fair_hold0",   1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
      step("fair_hand3",   1'b0, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0);
      step("fair_idle",    1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0);

      // Two steady requesters: rotate every 4 cycles with the limit,
      // otherwise requester 0 keeps the grant.
      for (int i = 0; i < 10; i++) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
         eg = (((i / 4) % 2) == 1) ? 4'b0010 : 4'b0001;
         es = (((i / 4) % 2) == 1) ? 2'd1 : 2'd0;
`else
         eg = 4'b0001;
         es = 2'd0;
`endif
         step($sformatf("burst_two_%0d", i), 1'b0, 4'b0011, 4'b0011, eg, es, 1'b1, 1'b1);
      end
      step("burst_rel",    1'b0, 4'b0000, 4'b0011, 4'b0000, es, 1'b0, 1'b0);

      // Lone requester is never interrupted.
      for (int i = 0; i < 6; i++) begin
         step($sformatf("burst_one_%0d", i), 1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
      end
      step("one_rel",      1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Reset while requester 3 holds the grant.
      step("mid_g3",       1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
      step("mid_reset",    1'b1, 4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
      step("mid_after",    1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
      step("mid_rel",      1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Let the monitor drain the queue, with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      #2;
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d need 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
